// File: rtl/fabric_bus_arbiter.sv
// Round-robin owner arbiter for the shared fabric data bus (EN grant, turnaround, owner number).
// Optional ownership watchdog: define FABRIC_ARB_WDT_EN.
module fabric_bus_arbiter #(
  parameter int N_UNITS    = 4,
  parameter int START_WAIT = 8,
  parameter int WDT_CYCLES = 256
) (
  input  logic               CLK_B,
  input  logic               RESET,
  input  logic [N_UNITS-1:0] REQUEST,
  input  logic               BUSY_line_MASTER,
  output logic [N_UNITS-1:0] EN,
  output logic [3:0]         NUMBER_UNIT,
  output logic               GRANT_VALID,
  output logic               ABANDON,
  output logic               WDT_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_OWN,
    S_RELEASE
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [N_UNITS-1:0]   r_en;
  logic [N_UNITS-1:0]   w_en_next;
  logic [3:0]           r_num;
  logic [3:0]           w_num_next;
  logic                 r_gv;
  logic                 w_gv_next;
  logic                 r_abandon;
  logic                 w_abandon_next;
  logic [7:0]           r_wait;
  logic [7:0]           w_wait_next;
  logic [3:0]           r_last;
  logic [3:0]           w_last_next;
  logic                 w_release;
  logic [15:0]          w_req16;
  logic [3:0]           w_winner;
  logic [N_UNITS-1:0]   w_onehot;

`ifdef FABRIC_ARB_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0]     r_wdt_cnt;
  logic [WDT_W-1:0]     w_wdt_cnt_next;
  logic                 r_wdt_err;
  logic                 w_wdt_err_next;
`endif

  // Search order starts just after the previous owner and wraps modulo N_UNITS.
  function automatic logic [3:0] f_pick(input logic [15:0] req, input logic [3:0] last);
    logic       found;
    logic [3:0] win;
    logic [4:0] cand;
    found = 1'b0;
    win   = last;
    for (int i = 1; i <= N_UNITS; i++) begin
      cand = {1'b0, last} + 5'(i);
      if (cand >= 5'(N_UNITS)) cand = cand - 5'(N_UNITS);
      if (!found && req[cand[3:0]]) begin
        found = 1'b1;
        win   = cand[3:0];
      end
    end
    return win;
  endfunction

  assign w_req16  = 16'(REQUEST);
  assign w_winner = f_pick(w_req16, r_last);

  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_onehot
    assign w_onehot[gi] = (w_winner == 4'(gi));
  end

  always_comb begin
    w_state_next   = r_state;
    w_en_next      = r_en;
    w_num_next     = r_num;
    w_gv_next      = r_gv;
    w_abandon_next = 1'b0;
    w_wait_next    = r_wait;
    w_last_next    = r_last;
    w_release      = 1'b0;
`ifdef FABRIC_ARB_WDT_EN
    w_wdt_cnt_next = r_wdt_cnt;
    w_wdt_err_next = r_wdt_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (|REQUEST) begin
          w_en_next    = w_onehot;
          w_num_next   = w_winner;
          w_gv_next    = 1'b1;
          w_wait_next  = '0;
          w_state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        if (BUSY_line_MASTER) begin
          w_state_next = S_OWN;
`ifdef FABRIC_ARB_WDT_EN
          w_wdt_cnt_next = '0;
`endif
        end else if (!w_req16[r_num]) begin
          w_release = 1'b1;
        end else if (r_wait == 8'(START_WAIT - 1)) begin
          w_release      = 1'b1;
          w_abandon_next = 1'b1;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_OWN: begin
        if (!BUSY_line_MASTER) begin
          w_release = 1'b1;
        end
`ifdef FABRIC_ARB_WDT_EN
        else if (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1)) begin
          w_release      = 1'b1;
          w_wdt_err_next = 1'b1;
        end else begin
          w_wdt_cnt_next = r_wdt_cnt + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Every exit from ownership funnels through the one-cycle turnaround.
    if (w_release) begin
      w_en_next    = '0;
      w_gv_next    = 1'b0;
      w_last_next  = r_num;
      w_state_next = S_RELEASE;
    end
  end

  always_ff @(posedge CLK_B) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_en      <= '0;
      r_num     <= '0;
      r_gv      <= 1'b0;
      r_abandon <= 1'b0;
      r_wait    <= '0;
      r_last    <= 4'(N_UNITS - 1);
`ifdef FABRIC_ARB_WDT_EN
      r_wdt_cnt <= '0;
      r_wdt_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_en      <= w_en_next;
      r_num     <= w_num_next;
      r_gv      <= w_gv_next;
      r_abandon <= w_abandon_next;
      r_wait    <= w_wait_next;
      r_last    <= w_last_next;
`ifdef FABRIC_ARB_WDT_EN
      r_wdt_cnt <= w_wdt_cnt_next;
      r_wdt_err <= w_wdt_err_next;
`endif
    end
  end

  assign EN          = r_en;
  assign NUMBER_UNIT = r_num;
  assign GRANT_VALID = r_gv;
  assign ABANDON     = r_abandon;

`ifdef FABRIC_ARB_WDT_EN
  assign WDT_ERR = r_wdt_err;
`else
  // Without the watchdog ownership is unbounded and the flag is constant low.
  assign WDT_ERR = 1'b0 & (WDT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_fabric_bus_arbiter.sv
// Scoreboard bench for fabric_bus_arbiter: directed scenarios push expected grants, a monitor checks them.
module tb_fabric_bus_arbiter;

  logic       CLK_B = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] REQUEST = 4'b0000;
  logic       BUSY_line_MASTER = 1'b0;
  logic [3:0] EN;
  logic [3:0] NUMBER_UNIT;
  logic       GRANT_VALID;
  logic       ABANDON;
  logic       WDT_ERR;

  fabric_bus_arbiter #(
    .N_UNITS   (4),
    .START_WAIT(8),
    .WDT_CYCLES(16)
  ) dut (
    .CLK_B           (CLK_B),
    .RESET           (RESET),
    .REQUEST         (REQUEST),
    .BUSY_line_MASTER(BUSY_line_MASTER),
    .EN              (EN),
    .NUMBER_UNIT     (NUMBER_UNIT),
    .GRANT_VALID     (GRANT_VALID),
    .ABANDON         (ABANDON),
    .WDT_ERR         (WDT_ERR)
  );

  always #5 CLK_B = ~CLK_B;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unit;
    int hold;
    int abandon;
  } txn_t;
  txn_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_txn(input int u, input int h, input int a);
    txn_t t;
    t.unit = u;
    t.hold = h;
    t.abandon = a;
    sb.push_back(t);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK_B);
    #1;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (EN == 4'b0000 && waited < 20) begin
      step(1);
      waited++;
    end
    chk("grant_seen", int'(EN != 4'b0000), 1);
  endtask

  task automatic wait_release(output int waited);
    waited = 0;
    while (EN != 4'b0000 && waited < 60) begin
      step(1);
      waited++;
    end
    chk("release_seen", int'(EN == 4'b0000), 1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQUEST = 4'b0000;
    BUSY_line_MASTER = 1'b0;
    step(2);
    chk("reset_state", int'({EN, NUMBER_UNIT, GRANT_VALID, ABANDON, WDT_ERR}), 0);
    RESET = 1'b0;
  endtask

  // Monitor: a transaction is one contiguous EN-high interval.
  bit         m_active = 1'b0;
  bit         m_stable;
  int         m_hold;
  int         m_gap = 100;
  int         m_unit;
  int         m_txn = 0;
  logic [3:0] m_en;
  txn_t       m_t;

  always @(negedge CLK_B) begin
    if (!$isunknown(EN) && EN != 4'b0000) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_hold = 0;
        m_stable = 1'b1;
        m_en = EN;
        m_unit = int'(NUMBER_UNIT);
        chk("grant_onehot", int'(EN), 1 << NUMBER_UNIT);
        chk("grant_valid", int'(GRANT_VALID), 1);
        chk("gap_min2", int'(m_gap >= 2), 1);
      end else if (EN != m_en) begin
        m_stable = 1'b0;
      end
      m_hold++;
    end else begin
      if (m_active) begin
        m_active = 1'b0;
        m_gap = 0;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL txn_unexpected: unit=%0d hold=%0d abandon=%0d, none expected",
                   m_unit, m_hold, ABANDON);
        end else begin
          m_t = sb.pop_front();
          if (m_unit == m_t.unit && m_hold == m_t.hold && int'(ABANDON) == m_t.abandon && m_stable) begin
            $display("TXN %0d unit=%0d hold=%0d abandon=%0d ok", m_txn, m_unit, m_hold, ABANDON);
          end else begin
            n_fail++;
            $display("FAIL txn %0d: got unit=%0d hold=%0d abandon=%0d stable=%0d required unit=%0d hold=%0d abandon=%0d stable=1",
                     m_txn, m_unit, m_hold, ABANDON, m_stable, m_t.unit, m_t.hold, m_t.abandon);
          end
        end
        m_txn++;
      end
      m_gap++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    do_reset();

    // Single grant with a BUSY window in cycles 3-6.
    expect_txn(0, 7, 0);
    REQUEST = 4'b0001;
    step(3);
    BUSY_line_MASTER = 1'b1;
    step(4);
    BUSY_line_MASTER = 1'b0;
    REQUEST = 4'b0000;
    step(1);
    chk("single_en_low_c8", int'(EN), 0);
    chk("single_num_kept", int'(NUMBER_UNIT), 0);
    step(3);

    // Round-robin with all units requesting.
    do_reset();
    expect_txn(0, 3, 0);
    expect_txn(1, 3, 0);
    expect_txn(2, 3, 0);
    expect_txn(3, 3, 0);
    expect_txn(0, 3, 0);
    REQUEST = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(w);
      chk(k == 0 ? "rr_latency" : "rr_regrant_gap", w, k == 0 ? 1 : 2);
      BUSY_line_MASTER = 1'b1;
      if (k == 4) REQUEST = 4'b0000;
      step(2);
      BUSY_line_MASTER = 1'b0;
      step(1);
    end
    step(3);

    // Abandon after START_WAIT, then re-grant of the same unit.
    do_reset();
    expect_txn(2, 8, 1);
    expect_txn(2, 1, 0);
    REQUEST = 4'b0100;
    wait_grant(w);
    wait_release(w);
    chk("abandon_hold", w, 8);
    chk("abandon_pulse", int'(ABANDON), 1);
    step(1);
    chk("abandon_one_cycle", int'(ABANDON), 0);
    wait_grant(w);
    chk("abandon_regrant_gap", w, 1);
    chk("abandon_regrant_unit", int'(NUMBER_UNIT), 2);
    REQUEST = 4'b0000;
    step(3);

    // Early withdraw, then wrap-around search from unit 2.
    do_reset();
    expect_txn(1, 3, 0);
    expect_txn(0, 1, 0);
    REQUEST = 4'b0010;
    step(3);
    REQUEST = 4'b0000;
    step(1);
    chk("withdraw_en_low", int'(EN), 0);
    chk("withdraw_no_abandon", int'(ABANDON), 0);
    REQUEST = 4'b0011;
    wait_grant(w);
    chk("withdraw_wrap_unit", int'(NUMBER_UNIT), 0);
    REQUEST = 4'b0000;
    step(3);

    // Reset while unit 3 owns the bus.
    do_reset();
    expect_txn(3, 3, 0);
    expect_txn(0, 1, 0);
    REQUEST = 4'b1000;
    step(1);
    BUSY_line_MASTER = 1'b1;
    step(2);
    RESET = 1'b1;
    step(1);
    chk("midown_reset_outputs", int'({EN, NUMBER_UNIT, GRANT_VALID, ABANDON, WDT_ERR}), 0);
    step(1);
    RESET = 1'b0;
    BUSY_line_MASTER = 1'b0;
    REQUEST = 4'b1001;
    wait_grant(w);
    chk("post_reset_unit", int'(NUMBER_UNIT), 0);
    REQUEST = 4'b0000;
    step(3);

    // BUSY high with no owner, then a stuck owner.
    do_reset();
    BUSY_line_MASTER = 1'b1;
    step(3);
    chk("busy_idle_ignored", int'(EN), 0);
`ifdef FABRIC_ARB_WDT_EN
    expect_txn(0, 17, 0);
    expect_txn(0, 1, 0);
    REQUEST = 4'b0001;
    step(1);
    REQUEST = 4'b0000;
    step(16);
    chk("wdt_en_held", int'(EN), 1);
    chk("wdt_err_before", int'(WDT_ERR), 0);
    step(1);
    chk("wdt_en_forced_low", int'(EN), 0);
    chk("wdt_err_set", int'(WDT_ERR), 1);
    step(5);
    chk("wdt_idle_busy_ignored", int'(EN), 0);
    BUSY_line_MASTER = 1'b0;
    REQUEST = 4'b0001;
    wait_grant(w);
    chk("wdt_stuck_unit_eligible", int'(NUMBER_UNIT), 0);
    REQUEST = 4'b0000;
    step(3);
    chk("wdt_err_sticky", int'(WDT_ERR), 1);
`else
    expect_txn(0, 41, 0);
    REQUEST = 4'b0001;
    step(1);
    REQUEST = 4'b0000;
    step(39);
    chk("nowdt_en_held", int'(EN), 1);
    chk("nowdt_err_low", int'(WDT_ERR), 0);
    step(1);
    BUSY_line_MASTER = 1'b0;
    step(1);
    chk("nowdt_release", int'(EN), 0);
    step(3);
`endif
    do_reset();
    step(3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
